emin_stream: RTL
================

Name: emin_stream

Overview:
Parametrised successor to the fixed three-coefficient Emin stage in the formant path. For a requested row i, it computes Emin(j,i) for every j in a programmable range [j_lo, i]. It reads T rows from the external T BRAM and streams the results through an output FIFO with a ready/valid handshake, so the downstream writer may apply backpressure. Compared with the previous stage, it adds a start handshake, configurable fixed-point format, configurable BRAM latency, a degenerate-denominator flag and credit-based flow control.

Parameters:
BIT_WIDTH, 32, width of T entries and all datapath values (signed two's complement)
FRAC_BITS, 8, fractional bits of the fixed-point format; 1.0 = 2^FRAC_BITS
I, 160, number of T rows; address width is $clog2(I)
T_LATENCY, 2, cycles from T_req to T_resp valid
FIFO_DEPTH, 8, output FIFO entries (power of two, >= 2)

Ports:
clk_in  in  1  clock
rst_in  in  1  synchronous active-high reset
i_in  in  $clog2(I)  target row i
j_lo_in  in  $clog2(I)  first j to compute; must be <= i_in
input_valid  in  1  start request
input_ready  out  1  high only in IDLE
T_req  out  $clog2(I)  T BRAM read address
T_resp0, T_resp1, T_resp2  in  BIT_WIDTH each  T[addr][0..2], arriving T_LATENCY cycles after T_req
j_out  out  $clog2(I)  j of the head FIFO entry
data_out  out  BIT_WIDTH  Emin(j,i)
degen_out  out  1  denom was 0 for this entry
output_valid  out  1  FIFO not empty
output_ready  in  1  consumer accepts the head entry
busy_out  out  1  high from accept until the last entry is popped

Behaviour:
- Reset: state=IDLE; FIFO empty; in-flight count 0; output_valid=0; busy_out=0; T_req=0; j_out, data_out and degen_out = 0.
- Clock and reset: one clock, clk_in; reset is synchronous and active-high on rst_in. Reset mid-operation discards all in-flight work and FIFO contents with no partial outputs, and the block is ready again the following cycle.
- State LOAD_I: entered on input_valid && input_ready. Latch i and j_lo, drive T_req=i, wait T_LATENCY cycles, latch T_i[0..2], then go to ISSUE.
- State ISSUE: one j per cycle, starting at j_lo.
  - j=0 needs no read.
  - j>0 drives T_req=j-1.
  - Issue is allowed only while FIFO occupancy + in-flight < FIFO_DEPTH; otherwise hold j.
  - After issuing j=i, go to DRAIN.
- State DRAIN: wait until in-flight=0 and the FIFO is empty, then go to IDLE. busy_out falls in the same cycle.
- Input handling: input_valid outside IDLE is ignored. i_in and j_lo_in are sampled only on accept. If j_lo > i, the block produces zero outputs and returns to IDLE via DRAIN.
- Arithmetic, per j:
  - Residuals: r_k = T_i[k] - T[j-1][k] for j>0; r_k = T_i[k] for j=0.
  - Multiply: M(a,b) = (a*b) >>> FRAC_BITS, computed at full 2*BIT_WIDTH signed precision, then truncated to BIT_WIDTH.
  - an = M(r0,r1) - M(r1,r2); bn = M(r0,r2) - M(r1,r1); d = M(r0,r0) - M(r1,r1).
  - alpha = (an << FRAC_BITS) / d and beta = (bn << FRAC_BITS) / d: signed, truncated toward zero, saturated to the BIT_WIDTH signed range.
  - If d == 0: alpha = beta = 0 and degen=1.
  - Emin = r0 - M(r1,alpha) - M(r2,beta), wrapping at BIT_WIDTH.
- Pipeline: fully pipelined, accepting one j per cycle. Latency is fixed by the implementation and must be documented in the RTL header. Results enter the FIFO in ascending j order.
- FIFO handshake: a pop happens on output_valid && output_ready. Push and pop in the same cycle are both allowed when full. The credit rule above guarantees the FIFO never overflows. The outputs always reflect the head entry.

Test Plan:
- FRAC_BITS=8, i=0, j_lo=0, T[0]={512,256,0}, output_ready=1 -> one entry: j=0, alpha=170, beta=-85, data_out=342, degen=0; busy_out then falls.
- i=3, j_lo=0, T rows with T[3]={768,256,0} and T[0..2]={256,0,0} -> four entries j=0..3 in order. Entries j=1..3 have r={512,256,0} and data_out=342.
- Entry with r0=r1=256 (so d=0) -> degen_out=1, data_out=r0 - 0 = 256.
- i=20, j_lo=5, output_ready held low for 50 cycles then released -> exactly 16 entries j=5..20, no loss or duplication. FIFO occupancy never exceeds FIFO_DEPTH and T_req stalls while credits are exhausted.
- Assert rst_in in the middle of an i=20 run -> output_valid=0 next cycle, input_ready=1; a following run for i=0 yields only the correct single entry.
- input_valid pulsed during ISSUE with a different i -> ignored; the original run completes unchanged, and j_lo=7, i=4 yields zero entries.

Source files
------------

// File: rtl/emin_stream_if.sv
`default_nettype none
// ============================================================================
//  Module      : emin_stream_if
//  Description : Bundles the start handshake, T BRAM read port and result
//                stream of emin_stream.
//                  master : the emin_stream side (drives T_req, results)
//                  slave  : the environment side (start requests, T BRAM
//                           responses, result consumer)
//                BIT_WIDTH and I must match the emin_stream instance.
//  Revision    : 1.0 - initial release
// ============================================================================
interface emin_stream_if #(
  parameter int BIT_WIDTH = 32,
  parameter int I         = 160
);
  localparam int AW = $clog2(I);

  // start handshake
  logic [AW-1:0]               i_in;
  logic [AW-1:0]               j_lo_in;
  logic                        input_valid;
  logic                        input_ready;
  // T BRAM read port
  logic [AW-1:0]               T_req;
  logic signed [BIT_WIDTH-1:0] T_resp0;
  logic signed [BIT_WIDTH-1:0] T_resp1;
  logic signed [BIT_WIDTH-1:0] T_resp2;
  // result stream (head of the output FIFO)
  logic [AW-1:0]               j_out;
  logic signed [BIT_WIDTH-1:0] data_out;
  logic                        degen_out;
  logic                        output_valid;
  logic                        output_ready;
  logic                        busy_out;

  modport master (
    input  i_in, j_lo_in, input_valid, T_resp0, T_resp1, T_resp2, output_ready,
    output input_ready, T_req, j_out, data_out, degen_out, output_valid, busy_out
  );

  modport slave (
    output i_in, j_lo_in, input_valid, T_resp0, T_resp1, T_resp2, output_ready,
    input  input_ready, T_req, j_out, data_out, degen_out, output_valid, busy_out
  );
endinterface
`default_nettype wire

// File: rtl/emin_stream.sv
`default_nettype none
// ============================================================================
//  Module      : emin_stream
//  Description : For a requested row i, computes Emin(j,i) for every j in
//                [j_lo, i] and streams (j, Emin, degen) through an output
//                FIFO with ready/valid handshake.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk_in, rst_in : clock, synchronous active-high reset
//    bus (master)   : i_in/j_lo_in/input_valid/input_ready  start handshake
//                     T_req / T_resp0..2                     T BRAM read
//                     j_out/data_out/degen_out/output_valid/
//                     output_ready                           result stream
//                     busy_out                               run in progress
//
//  Pipeline latency
//    A j issued in cycle n presents T_req in cycle n+1, the BRAM answers in
//    cycle n+1+T_LATENCY, then three register stages follow (residuals,
//    products, quotients) and the entry is written into the FIFO at the end
//    of cycle n+4+T_LATENCY. It is visible at the FIFO head (output_valid)
//    in cycle n+5+T_LATENCY at the earliest. One j is accepted per cycle.
//
//  Flow control
//    Every issued j holds one credit until it is written into the FIFO, so
//    FIFO occupancy + in-flight entries never exceeds FIFO_DEPTH.
// ============================================================================
module emin_stream #(
  parameter int BIT_WIDTH  = 32,
  parameter int FRAC_BITS  = 8,
  parameter int I          = 160,
  parameter int T_LATENCY  = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic          clk_in,
  input  logic          rst_in,
  emin_stream_if.master bus
);

  localparam int AW = $clog2(I);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int LW = $clog2(T_LATENCY + 1) + 1;
  localparam int DW = 2 * BIT_WIDTH;

  localparam logic signed [DW-1:0] SAT_MAX = {{(BIT_WIDTH+1){1'b0}}, {(BIT_WIDTH-1){1'b1}}};
  localparam logic signed [DW-1:0] SAT_MIN = {{(BIT_WIDTH+1){1'b1}}, {(BIT_WIDTH-1){1'b0}}};

  typedef logic signed [BIT_WIDTH-1:0] data_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD_I = 2'd1,
    S_ISSUE  = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  // Fixed-point multiply: full-precision product, arithmetic shift, truncate.
  function automatic data_t fx_mul(input data_t a, input data_t b);
    logic signed [DW-1:0] p;
    p = DW'(a) * DW'(b);
    p = p >>> FRAC_BITS;
    return p[BIT_WIDTH-1:0];
  endfunction

  // Fixed-point divide (n << FRAC_BITS) / d, truncating toward zero and
  // saturating to the data range. A zero divisor yields 0.
  function automatic data_t fx_div(input data_t n, input data_t d);
    logic signed [DW-1:0] num;
    logic signed [DW-1:0] den;
    logic signed [DW-1:0] q;
    num = DW'(n);
    num = num <<< FRAC_BITS;
    den = DW'(d);
    if (d == '0) begin
      q = '0;
    end else begin
      q = num / den;
    end
    if (q > SAT_MAX) begin
      q = SAT_MAX;
    end else if (q < SAT_MIN) begin
      q = SAT_MIN;
    end
    return q[BIT_WIDTH-1:0];
  endfunction

  // ---------------------------------------------------------------- control
  state_t          state_q, state_d;
  logic [AW-1:0]   i_q, i_d;
  logic [AW-1:0]   j_lo_q, j_lo_d;
  logic [AW-1:0]   j_q, j_d;
  logic [AW-1:0]   t_req_q, t_req_d;
  logic [LW-1:0]   lat_q, lat_d;
  data_t           ti0_q, ti0_d, ti1_q, ti1_d, ti2_q, ti2_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic            busy_q, busy_d;
  logic            ready_q, ready_d;

  // ---------------------------------------------------------------- FIFO
  logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   mem_j_q     [FIFO_DEPTH];
  data_t           mem_data_q  [FIFO_DEPTH];
  logic            mem_degen_q [FIFO_DEPTH];

  // ------------------------------------------- tags waiting on BRAM data
  logic            tag_valid_q [0:T_LATENCY];
  logic            tag_valid_d [0:T_LATENCY];
  logic [AW-1:0]   tag_j_q     [0:T_LATENCY];
  logic [AW-1:0]   tag_j_d     [0:T_LATENCY];
  logic            tag_zero_q  [0:T_LATENCY];
  logic            tag_zero_d  [0:T_LATENCY];

  // ------------------------------------------------------ datapath stages
  logic            s1_valid_q, s1_valid_d;
  logic [AW-1:0]   s1_j_q, s1_j_d;
  data_t           s1_r0_q, s1_r0_d, s1_r1_q, s1_r1_d, s1_r2_q, s1_r2_d;

  logic            s2_valid_q, s2_valid_d;
  logic [AW-1:0]   s2_j_q, s2_j_d;
  data_t           s2_r0_q, s2_r0_d, s2_r1_q, s2_r1_d, s2_r2_q, s2_r2_d;
  data_t           s2_an_q, s2_an_d, s2_bn_q, s2_bn_d, s2_den_q, s2_den_d;

  logic            s3_valid_q, s3_valid_d;
  logic [AW-1:0]   s3_j_q, s3_j_d;
  data_t           s3_r0_q, s3_r0_d, s3_r1_q, s3_r1_d, s3_r2_q, s3_r2_d;
  data_t           s3_alpha_q, s3_alpha_d, s3_beta_q, s3_beta_d;
  logic            s3_degen_q, s3_degen_d;

  logic            issue;
  logic            credit_ok;
  logic            push;
  logic            pop;
  data_t           emin;

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_lo_d     = j_lo_q;
    j_d        = j_q;
    t_req_d    = t_req_q;
    lat_d      = lat_q;
    ti0_d      = ti0_q;
    ti1_d      = ti1_q;
    ti2_d      = ti2_q;
    busy_d     = busy_q;
    ready_d    = ready_q;
    issue      = 1'b0;
    credit_ok  = (int'(fifo_cnt_q) + int'(inflight_q)) < FIFO_DEPTH;
    push       = s3_valid_q;
    pop        = (fifo_cnt_q != '0) && bus.output_ready;

    case (state_q)
      S_IDLE: begin
        if (bus.input_valid) begin
          i_d     = bus.i_in;
          j_lo_d  = bus.j_lo_in;
          j_d     = bus.j_lo_in;
          t_req_d = bus.i_in;
          lat_d   = '0;
          busy_d  = 1'b1;
          ready_d = 1'b0;
          state_d = S_LOAD_I;
        end
      end
      S_LOAD_I: begin
        if (lat_q == LW'(T_LATENCY)) begin
          ti0_d   = bus.T_resp0;
          ti1_d   = bus.T_resp1;
          ti2_d   = bus.T_resp2;
          // an empty range still passes through DRAIN on its way to IDLE
          state_d = (j_lo_q > i_q) ? S_DRAIN : S_ISSUE;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      S_ISSUE: begin
        if (credit_ok) begin
          issue = 1'b1;
          // j=0 uses T_i alone, so the BRAM address is left untouched
          if (j_q != '0) begin
            t_req_d = j_q - AW'(1);
          end
          if (j_q == i_q) begin
            state_d = S_DRAIN;
          end else begin
            j_d = j_q + AW'(1);
          end
        end
      end
      S_DRAIN: begin
        if ((inflight_q == '0) && (fifo_cnt_q == '0)) begin
          busy_d  = 1'b0;
          ready_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    inflight_d = inflight_q + CW'(issue) - CW'(push);
    fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
    wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

    // Tags travel alongside the BRAM read so they line up with T_resp.
    tag_valid_d[0] = issue;
    tag_j_d[0]     = j_q;
    tag_zero_d[0]  = (j_q == '0);
    for (int k = 1; k <= T_LATENCY; k++) begin
      tag_valid_d[k] = tag_valid_q[k-1];
      tag_j_d[k]     = tag_j_q[k-1];
      tag_zero_d[k]  = tag_zero_q[k-1];
    end

    // Stage 1: residuals
    s1_valid_d = tag_valid_q[T_LATENCY];
    s1_j_d     = tag_j_q[T_LATENCY];
    if (tag_zero_q[T_LATENCY]) begin
      s1_r0_d = ti0_q;
      s1_r1_d = ti1_q;
      s1_r2_d = ti2_q;
    end else begin
      s1_r0_d = ti0_q - bus.T_resp0;
      s1_r1_d = ti1_q - bus.T_resp1;
      s1_r2_d = ti2_q - bus.T_resp2;
    end

    // Stage 2: numerators and denominator
    s2_valid_d = s1_valid_q;
    s2_j_d     = s1_j_q;
    s2_r0_d    = s1_r0_q;
    s2_r1_d    = s1_r1_q;
    s2_r2_d    = s1_r2_q;
    s2_an_d    = fx_mul(s1_r0_q, s1_r1_q) - fx_mul(s1_r1_q, s1_r2_q);
    s2_bn_d    = fx_mul(s1_r0_q, s1_r2_q) - fx_mul(s1_r1_q, s1_r1_q);
    s2_den_d   = fx_mul(s1_r0_q, s1_r0_q) - fx_mul(s1_r1_q, s1_r1_q);

    // Stage 3: alpha / beta (forced to zero on a degenerate denominator)
    s3_valid_d = s2_valid_q;
    s3_j_d     = s2_j_q;
    s3_r0_d    = s2_r0_q;
    s3_r1_d    = s2_r1_q;
    s3_r2_d    = s2_r2_q;
    s3_degen_d = (s2_den_q == '0);
    s3_alpha_d = fx_div(s2_an_q, s2_den_q);
    s3_beta_d  = fx_div(s2_bn_q, s2_den_q);

    // Emin is formed on the way into the FIFO; wraps at BIT_WIDTH.
    emin = s3_r0_q - fx_mul(s3_r1_q, s3_alpha_q) - fx_mul(s3_r2_q, s3_beta_q);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      i_q        <= '0;
      j_lo_q     <= '0;
      j_q        <= '0;
      t_req_q    <= '0;
      lat_q      <= '0;
      ti0_q      <= '0;
      ti1_q      <= '0;
      ti2_q      <= '0;
      inflight_q <= '0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      for (int k = 0; k <= T_LATENCY; k++) begin
        tag_valid_q[k] <= 1'b0;
        tag_j_q[k]     <= '0;
        tag_zero_q[k]  <= 1'b0;
      end
      s1_valid_q <= 1'b0;
      s1_j_q     <= '0;
      s1_r0_q    <= '0;
      s1_r1_q    <= '0;
      s1_r2_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_j_q     <= '0;
      s2_r0_q    <= '0;
      s2_r1_q    <= '0;
      s2_r2_q    <= '0;
      s2_an_q    <= '0;
      s2_bn_q    <= '0;
      s2_den_q   <= '0;
      s3_valid_q <= 1'b0;
      s3_j_q     <= '0;
      s3_r0_q    <= '0;
      s3_r1_q    <= '0;
      s3_r2_q    <= '0;
      s3_alpha_q <= '0;
      s3_beta_q  <= '0;
      s3_degen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_lo_q     <= j_lo_d;
      j_q        <= j_d;
      t_req_q    <= t_req_d;
      lat_q      <= lat_d;
      ti0_q      <= ti0_d;
      ti1_q      <= ti1_d;
      ti2_q      <= ti2_d;
      inflight_q <= inflight_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      fifo_cnt_q <= fifo_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      for (int k = 0; k <= T_LATENCY; k++) begin
        tag_valid_q[k] <= tag_valid_d[k];
        tag_j_q[k]     <= tag_j_d[k];
        tag_zero_q[k]  <= tag_zero_d[k];
      end
      s1_valid_q <= s1_valid_d;
      s1_j_q     <= s1_j_d;
      s1_r0_q    <= s1_r0_d;
      s1_r1_q    <= s1_r1_d;
      s1_r2_q    <= s1_r2_d;
      s2_valid_q <= s2_valid_d;
      s2_j_q     <= s2_j_d;
      s2_r0_q    <= s2_r0_d;
      s2_r1_q    <= s2_r1_d;
      s2_r2_q    <= s2_r2_d;
      s2_an_q    <= s2_an_d;
      s2_bn_q    <= s2_bn_d;
      s2_den_q   <= s2_den_d;
      s3_valid_q <= s3_valid_d;
      s3_j_q     <= s3_j_d;
      s3_r0_q    <= s3_r0_d;
      s3_r1_q    <= s3_r1_d;
      s3_r2_q    <= s3_r2_d;
      s3_alpha_q <= s3_alpha_d;
      s3_beta_q  <= s3_beta_d;
      s3_degen_q <= s3_degen_d;
    end
  end

  // FIFO storage carries no reset; validity is tracked by fifo_cnt_q.
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem_j_q[wr_ptr_q]     <= s3_j_q;
      mem_data_q[wr_ptr_q]  <= emin;
      mem_degen_q[wr_ptr_q] <= s3_degen_q;
    end
  end

  assign bus.input_ready  = ready_q;
  assign bus.busy_out     = busy_q;
  assign bus.T_req        = t_req_q;
  assign bus.output_valid = (fifo_cnt_q != '0);
  assign bus.j_out        = (fifo_cnt_q != '0) ? mem_j_q[rd_ptr_q]     : '0;
  assign bus.data_out     = (fifo_cnt_q != '0) ? mem_data_q[rd_ptr_q]  : '0;
  assign bus.degen_out    = (fifo_cnt_q != '0) ? mem_degen_q[rd_ptr_q] : 1'b0;

endmodule
`default_nettype wire
